// File: rtl/line_sram_responder_if.sv
// Line-access SRAM bus between a 2D-pipeline master and the responder.
// Carries single-cycle line requests, the registered line result and clear status.
interface line_sram_responder_if #(
  parameter int ADDR_SIZE_BITS = 24,
  parameter int LW             = 1536
);
  logic                      read_enable;
  logic                      write_enable;
  logic [ADDR_SIZE_BITS-1:0] address;
  logic [LW-1:0]             write_data;
  logic [LW-1:0]             read_data;
  logic                      clear_en;
  logic                      busy;
  logic                      clear_done;
  logic                      error;

  modport master (
    output read_enable, write_enable, address, write_data, clear_en,
    input  read_data, busy, clear_done, error
  );

  modport slave (
    input  read_enable, write_enable, address, write_data, clear_en,
    output read_data, busy, clear_done, error
  );
endinterface

// File: rtl/line_sram_responder.sv
// Line-wide SRAM responder: one registered line per read, one line per write.
// A clear engine zeroes every line, one per cycle, while requests are rejected.
module line_sram_responder #(
  parameter int ADDR_SIZE_BITS  = 24,
  parameter int WORD_SIZE_BYTES = 3,
  parameter int DATA_SIZE_WORDS = 64,
  parameter int NUM_LINES       = 64,
  parameter int BASE_ADDR       = 0
) (
  input logic                   clk,
  input logic                   n_rst,
  line_sram_responder_if.slave  bus
);
  localparam int AW    = ADDR_SIZE_BITS;
  localparam int LW    = WORD_SIZE_BYTES * DATA_SIZE_WORDS * 8;
  localparam int WIDX  = $clog2(DATA_SIZE_WORDS);
  localparam int LIDX  = $clog2(NUM_LINES);
  localparam int SPANB = WIDX + LIDX;
  localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [LIDX-1:0] cnt_q, cnt_d;
  logic [LW-1:0]   rdata_q, rdata_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [LW-1:0]   mem_q [NUM_LINES];

  logic [AW-1:0]   offset;
  logic            below;
  logic            legal;
  logic [LIDX-1:0] idx;
  logic            req;
  logic            wr_line;
  logic            clr_line;

  // The borrow of the subtraction flags addresses below the window.
  assign {below, offset} = {1'b0, bus.address} - {1'b0, BASE};
  assign legal = !below
              && (offset[WIDX-1:0] == '0)
              && (offset[AW-1:SPANB] == '0);
  assign idx = offset[WIDX +: LIDX];
  assign req = bus.read_enable || bus.write_enable;

  // Next state, request decode and registered output values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    wr_line  = 1'b0;
    clr_line = 1'b0;
    unique case (state_q)
      IDLE: begin
        err_d = req && !legal;
        if (bus.read_enable) begin
          rdata_d = legal ? mem_q[idx] : '0;
        end
        wr_line = bus.write_enable && legal;
        if (bus.clear_en) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        err_d    = req;
        clr_line = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        err_d   = req;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == CLEAR);
    done_d = (state_d == DONE);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Line storage; not reset, so a reset mid-clear leaves it partly zeroed.
  always_ff @(posedge clk) begin
    if (wr_line) begin
      mem_q[idx] <= bus.write_data;
    end
    if (clr_line) begin
      mem_q[cnt_q] <= '0;
    end
  end

  assign bus.read_data  = rdata_q;
  assign bus.busy       = busy_q;
  assign bus.clear_done = done_q;
  assign bus.error      = err_q;
endmodule

// File: tb/tb_line_sram_responder.sv
// Randomised scoreboard bench for line_sram_responder.
// Expected responses are queued at issue time and popped by a monitor.
module tb_line_sram_responder;
  localparam int AW   = 24;
  localparam int WB   = 3;
  localparam int DW   = 64;
  localparam int NL   = 64;
  localparam int BASE = 0;
  localparam int LW   = WB * DW * 8;

  typedef struct {
    logic          err;
    logic [LW-1:0] rd;
  } exp_t;

  logic clk;
  logic n_rst;

  line_sram_responder_if #(.ADDR_SIZE_BITS(AW), .LW(LW)) bus ();

  line_sram_responder #(
    .ADDR_SIZE_BITS (AW),
    .WORD_SIZE_BYTES(WB),
    .DATA_SIZE_WORDS(DW),
    .NUM_LINES      (NL),
    .BASE_ADDR      (BASE)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  int            n_chk  = 0;
  int            n_fail = 0;
  exp_t          expq[$];
  logic [LW-1:0] model_mem [NL];
  logic [LW-1:0] model_rd;
  bit            clearing;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [LW-1:0] act,
                      input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      for (int k = 0; k < DW; k++) begin
        if (act[k*24 +: 24] !== exp[k*24 +: 24]) begin
          $display("FAIL %s word %0d actual=%h required=%h",
                   name, k, act[k*24 +: 24], exp[k*24 +: 24]);
          break;
        end
      end
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic bit legal_a(input logic [AW-1:0] a);
    longint o;
    o = longint'(a) - BASE;
    if (o < 0) return 1'b0;
    return (o % DW == 0) && (o / DW < NL);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.read_enable  = 1'b0;
    bus.write_enable = 1'b0;
    bus.clear_en     = 1'b0;
  endtask

  // Drive one request and queue the response the model predicts for it.
  task automatic issue(input bit re, input bit we, input logic [AW-1:0] a,
                       input logic [LW-1:0] d);
    exp_t   e;
    bit     lg;
    longint li;
    lg = legal_a(a);
    li = (longint'(a) - BASE) / DW;
    bus.read_enable  = re;
    bus.write_enable = we;
    bus.address      = a;
    bus.write_data   = d;
    if (clearing) begin
      e.err = 1'b1;
    end else begin
      e.err = !lg;
      if (re) model_rd = lg ? model_mem[int'(li)] : '0;
      if (we && lg) model_mem[int'(li)] = d;
    end
    e.rd = model_rd;
    expq.push_back(e);
  endtask

  // Monitor: every sampled request produces one checked response.
  logic mreq;
  exp_t me;
  always @(posedge clk) begin
    mreq = n_rst && (bus.read_enable || bus.write_enable);
    #1;
    if (mreq) begin
      if (expq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_empty actual=response required=none");
      end else begin
        me = expq.pop_front();
        chk1("error", bus.error, me.err);
        chkw("read_data", bus.read_data, me.rd);
      end
    end else if (n_rst) begin
      chk1("error_no_req", bus.error, 1'b0);
    end
  end

  // Start a clear; optionally read, re-clear or reset at a given busy cycle.
  task automatic run_clear(input int rd_at, input int clr_at, input int rst_at);
    int n;
    bit was_reset;
    n = 0;
    was_reset = 1'b0;
    bus.clear_en = 1'b1;
    tick();
    bus.clear_en = 1'b0;
    clearing = 1'b1;
    while (bus.busy && n < 200) begin
      n++;
      if (n == rst_at) begin
        n_rst = 1'b0;
        #1;
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_done", bus.clear_done, 1'b0);
        chk1("rst_error", bus.error, 1'b0);
        chkw("rst_read_data", bus.read_data, '0);
        for (int l = 0; l < n - 1; l++) model_mem[l] = '0;
        model_rd = '0;
        clearing = 1'b0;
        tick();
        tick();
        n_rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
          tick();
          chk1("post_rst_done", bus.clear_done, 1'b0);
          chk1("post_rst_busy", bus.busy, 1'b0);
        end
        was_reset = 1'b1;
        break;
      end
      if (n == rd_at) issue(1'b1, 1'b0, '0, '0);
      if (n == clr_at) bus.clear_en = 1'b1;
      tick();
      idle();
    end
    if (!was_reset) begin
      n_chk++;
      if (n != NL) begin
        n_fail++;
        $display("FAIL busy_cycles actual=%0d required=%0d", n, NL);
      end
      chk1("clear_done_pulse", bus.clear_done, 1'b1);
      chk1("busy_at_done", bus.busy, 1'b0);
      for (int l = 0; l < NL; l++) model_mem[l] = '0;
      clearing = 1'b0;
      tick();
      chk1("clear_done_end", bus.clear_done, 1'b0);
    end
  endtask

  task automatic read_all();
    for (int l = 0; l < NL; l++) begin
      issue(1'b1, 1'b0, AW'(BASE + l * DW), '0);
      tick();
    end
    idle();
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] p1, p2, pa5;
    logic [AW-1:0] a;
    int            r, kind;
    clearing = 1'b0;
    model_rd = '0;
    n_rst = 1'b0;
    idle();
    bus.address    = '0;
    bus.write_data = '0;
    tick();
    chkw("reset_read_data", bus.read_data, '0);
    chk1("reset_busy", bus.busy, 1'b0);
    chk1("reset_clear_done", bus.clear_done, 1'b0);
    chk1("reset_error", bus.error, 1'b0);
    n_rst = 1'b1;
    tick();

    pa5 = {(LW/8){8'hA5}};
    issue(1'b0, 1'b1, AW'(0), pa5);
    tick();
    issue(1'b1, 1'b0, AW'(0), '0);
    tick();
    idle();
    tick();

    p1 = rnd_line();
    p2 = rnd_line();
    issue(1'b0, 1'b1, AW'(64), p1);
    tick();
    issue(1'b1, 1'b1, AW'(64), p2);
    tick();
    issue(1'b1, 1'b0, AW'(64), '0);
    tick();
    idle();
    tick();

    issue(1'b1, 1'b0, AW'(65), '0);
    tick();
    issue(1'b1, 1'b0, AW'(NL * DW), '0);
    tick();
    issue(1'b1, 1'b0, AW'(0), '0);
    tick();
    idle();
    tick();

    issue(1'b0, 1'b1, AW'(3 * DW), rnd_line());
    tick();
    issue(1'b0, 1'b1, AW'(7 * DW), rnd_line());
    tick();
    issue(1'b0, 1'b1, AW'(40 * DW), rnd_line());
    tick();
    idle();
    run_clear(10, 20, 0);
    read_all();

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8)
        a = AW'(BASE + $urandom_range(0, NL - 1) * DW);
      else if (r == 8)
        a = AW'(BASE + $urandom_range(0, NL - 1) * DW + $urandom_range(1, DW - 1));
      else
        a = AW'($urandom_range(NL * DW, (1 << AW) - 1));
      kind = $urandom_range(0, 3);
      if (kind == 3) idle();
      else issue(kind != 1, kind != 0, a, rnd_line());
      tick();
    end
    idle();
    tick();

    for (int l = 0; l < NL; l++) begin
      issue(1'b0, 1'b1, AW'(BASE + l * DW), rnd_line());
      tick();
    end
    idle();
    run_clear(0, 0, 31);
    read_all();

    tick();
    n_chk++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left actual=%0d required=0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/line_sram_responder.md
Name: line_sram_responder

Overview:
- Responder end of the wide line-access SRAM bus used by the 2D-pipeline masters (alpha blender, layer writers, texture fetch).
- Each request moves one full line of DATA_SIZE_WORDS pixels of WORD_SIZE_BYTES bytes. Reads are answered with a registered line one cycle later, which is the timing the masters' WAIT states expect.
- Holds NUM_LINES lines of on-chip storage mapped at BASE_ADDR.
- Includes a clear engine that zeroes the whole region.

Parameters:
- ADDR_SIZE_BITS, 24, word address width.
- WORD_SIZE_BYTES, 3, bytes per pixel word.
- DATA_SIZE_WORDS, 64, words per line; line data width LW = WORD_SIZE_BYTES*DATA_SIZE_WORDS*8 = 1536.
- NUM_LINES, 64, lines of storage; power of two.
- BASE_ADDR, 0, first word address served.

Ports:
- clk  in  1  clock, rising edge.
- n_rst  in  1  reset; asynchronous, active-low.
- read_enable  in  1  line read request, single-cycle.
- write_enable  in  1  line write request, single-cycle.
- address  in  ADDR_SIZE_BITS  word address of the line.
- write_data  in  LW  line to store; word k is at bits [k*24 +: 24].
- read_data  out  LW  registered read result.
- clear_en  in  1  start zeroing all lines.
- busy  out  1  high while the clear engine is running.
- clear_done  out  1  one-cycle pulse when the clear finishes.
- error  out  1  one-cycle pulse flagging a rejected or illegal request.

Behaviour:
- Reset values: read_data=0, busy=0, clear_done=0, error=0, state=IDLE, clear counter=0. Storage contents are not reset.
- Decode: offset = address - BASE_ADDR.
  - Legal only when offset[log2(DATA_SIZE_WORDS)-1:0]==0 and offset < NUM_LINES*DATA_SIZE_WORDS.
  - line index = offset / DATA_SIZE_WORDS.
  - Any address below BASE_ADDR is out of range.
- Read, accepted in IDLE:
  - On the edge that samples read_enable=1, read_data <= line[index].
  - The value is visible the cycle after the request. Latency 1.
  - read_data holds its value until the next accepted read.
- Write, accepted in IDLE: line[index] <= write_data on the sampling edge. No response data.
- Read and write in the same cycle:
  - Both are performed.
  - If they target the same line, read_data returns the pre-write contents (read-before-write).
- Illegal address (misaligned or out of range):
  - The access is dropped and storage is untouched.
  - error=1 for one cycle after the sampling edge.
  - On a read, read_data <= 0.
- State machine: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR when clear_en=1. busy=1 from the next cycle.
  - CLEAR: each cycle line[cnt] <= 0 and cnt++. After cnt=NUM_LINES-1 is written, go to DONE. Duration is exactly NUM_LINES cycles.
  - DONE: clear_done=1 and busy=0 for one cycle, cnt <= 0, then IDLE.
- Requests during CLEAR or DONE: ignored, storage is not modified by them, read_data holds, error pulses for one cycle.
- clear_en during CLEAR or DONE: ignored. No error.
- clear_en together with read/write in IDLE: the request is serviced in that cycle, then CLEAR starts.
- Reset mid-clear: immediately returns to IDLE with busy=0. Storage is left partially cleared and clear_done is not pulsed.
- error, clear_done and busy are registered outputs. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then write line 0xA5 pattern at address 0 and read address 0 -> read_data = pattern the cycle after the read; error stays 0.
- Write address 64 = P1. The next cycle, read and write address 64 = P2 together -> read_data = P1. A following read -> P2.
- Read address 65 (misaligned) and address NUM_LINES*64 = 4096 (out of range) -> error pulses one cycle each, read_data = 0, storage unchanged (verify by rereading line 0).
- Write three lines, pulse clear_en -> busy high for exactly 64 cycles, then clear_done pulses with busy=0. Reading every line returns 0.
- Issue a read during the clear at cycle 10 -> error pulse, read_data unchanged. A second clear_en at cycle 20 -> no effect, done still at cycle 64.
- Assert n_rst=0 at clear cycle 30 -> busy=0, outputs reset, no clear_done pulse. Lines 0..29 read 0; line 40 keeps its written data.
